wb_cmd_master: RTL and testbench
================================

# wb_cmd_master

Wishbone classic single-transfer initiator that turns a valid/ready command stream into bus cycles and returns a response stream. It sits in the user area alongside the project logic and drives the initiator side of the same 32-bit Wishbone interface that the management SoC uses as initiator into the user area. One transfer is outstanding at a time. Every cycle ends in exactly one response: ack, bus error or timeout.

## Interface
- `TIMEOUT`, default 256: number of strobe cycles without `ack`/`err` before the transfer is abandoned. Legal range 2..65535.
- `wb_clk_i` input 1: the only clock; all logic is on its rising edge.
- `wb_rst_i` input 1: reset, synchronous, active-high.
- `cmd_valid_i` input 1: a command is present.
- `cmd_ready_o` output 1: the block can accept a command.
- `cmd_we_i` input 1: 1 = write, 0 = read.
- `cmd_adr_i` input 32: byte address.
- `cmd_dat_i` input 32: write data.
- `cmd_sel_i` input 4: byte lane selects.
- `rsp_valid_o` output 1: a response is present.
- `rsp_ready_i` input 1: the consumer accepts the response.
- `rsp_dat_o` output 32: read data; 0 for writes, errors and timeouts.
- `rsp_err_o` output 1: the target terminated the cycle with `err`.
- `rsp_tmo_o` output 1: the cycle timed out.
- `wbm_cyc_o` output 1: Wishbone cycle.
- `wbm_stb_o` output 1: Wishbone strobe.
- `wbm_we_o` output 1: Wishbone write enable.
- `wbm_sel_o` output 4: Wishbone byte selects.
- `wbm_adr_o` output 32: Wishbone address.
- `wbm_dat_o` output 32: Wishbone write data.
- `wbm_dat_i` input 32: Wishbone read data.
- `wbm_ack_i` input 1: Wishbone acknowledge.
- `wbm_err_i` input 1: Wishbone error.

## Operation
- States: IDLE, BUS, RESP.
- **IDLE:** `cmd_ready_o`=1.
  - On `cmd_valid_i & cmd_ready_o`, register we, adr, dat and sel, clear the timeout counter, go to BUS.
- **BUS:** `wbm_cyc_o`=`wbm_stb_o`=1, and the `wbm_*` outputs hold the registered command.
  - `cmd_ready_o`=0.
  - The counter increments each BUS cycle in which neither `ack` nor `err` is seen.
- **Leaving BUS:** go to RESP on the first of these:
  - `wbm_err_i`=1: set `rsp_err_o`=1 and `rsp_dat_o`=0.
  - `wbm_ack_i`=1: for reads, capture `rsp_dat_o`=`wbm_dat_i`; for writes, `rsp_dat_o`=0.
  - Counter reaches `TIMEOUT`-1 with no termination: set `rsp_tmo_o`=1 and `rsp_dat_o`=0.
- **Simultaneous terminations:**
  - `ack` and `err` in the same cycle: `err` wins, and `rsp_err_o`=1.
  - A termination in the same cycle as the timeout terminal count: the termination wins, and `rsp_tmo_o`=0.
- **RESP:** `rsp_valid_o`=1, with all response fields stable until the handshake.
  - On `rsp_ready_i`=1, clear the flags and return to IDLE.
  - A new command can be accepted in the cycle after the handshake, not the same cycle.
- **Ignored inputs:** `wbm_ack_i` and `wbm_err_i` outside BUS are ignored. Command inputs outside IDLE are ignored.
- **Idle bus values:** `wbm_we_o`, `wbm_sel_o`, `wbm_adr_o` and `wbm_dat_o` are 0 whenever `wbm_cyc_o`=0.

## Timing
- **Reset values** (the cycle after `wb_rst_i` is sampled high):
  - State IDLE.
  - 0 on: `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`, `wbm_sel_o`, `wbm_adr_o`, `wbm_dat_o`, `rsp_valid_o`, `rsp_dat_o`, `rsp_err_o`, `rsp_tmo_o`.
  - `cmd_ready_o`=0 while `wb_rst_i`=1 and 1 after release.
- **Reset mid-operation:** reset in BUS or RESP drops `cyc`/`stb` and `rsp_valid_o` at the next edge. No response is produced for the aborted transfer.
- **Command to bus:** command accepted at edge N → `cyc`/`stb` high in cycle N+1.
- **Bus to response:** `ack`/`err` sampled at edge M → `cyc`/`stb` low and `rsp_valid_o` high in cycle M+1.
- **Zero-wait target:** `ack` in the first strobe cycle → response visible 2 cycles after command acceptance.
- **Timeout:** `cyc`/`stb` are high for exactly `TIMEOUT` cycles, then drop; `rsp_tmo_o` rises in the same cycle they drop.
- **Cycle integrity:** `stb` never deasserts mid-cycle without termination or timeout, and `cyc` = `stb` always (no pipelining, no bursts).
- **Throughput:** at most one transfer per 3 cycles, i.e. IDLE→BUS→RESP with immediate ack and immediate `rsp_ready_i`.

## Test plan
- **Write, 0 wait states:** cmd we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF; target acks in the first strobe cycle.
  - `wbm_*` carry exactly these values for 1 cycle.
  - Response: `rsp_dat_o`=0, err=0, tmo=0, `rsp_valid_o` 2 cycles after acceptance.
- **Read, 3 wait states:** cmd we=0, adr=0x3000_0010, sel=0x3; target returns 0x1234_5678 with ack on the 4th strobe cycle.
  - `stb` is high for 4 cycles.
  - `rsp_dat_o`=0x1234_5678.
- **Bus error and simultaneous terminations:**
  - `err` on the 2nd strobe cycle → `rsp_err_o`=1, `rsp_dat_o`=0.
  - `ack` and `err` together → `rsp_err_o`=1.
- **Timeout, `TIMEOUT`=8, target silent:**
  - `stb` is high for exactly 8 cycles, then `rsp_tmo_o`=1.
  - `ack` on exactly the 8th cycle → `rsp_tmo_o`=0 and normal data.
- **Backpressure:** hold `rsp_ready_i`=0 for 5 cycles with a command pending.
  - Response fields stay stable, `cmd_ready_o`=0 throughout, and there is no second bus cycle.
  - After the handshake, the next command is accepted one cycle later.
- **Reset mid-operation:** assert `wb_rst_i` during BUS (3rd strobe cycle).
  - `cyc`/`stb` are 0 next cycle and no `rsp_valid_o` is produced.
  - After release, a read completes normally.

Source files
------------

// File: rtl/wb_cmd_master_if.sv
// wb_cmd_master_if: command, response and Wishbone initiator signals of wb_cmd_master.
interface wb_cmd_master_if;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_we_i;
   logic [31:0] cmd_adr_i;
   logic [31:0] cmd_dat_i;
   logic [3:0]  cmd_sel_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_dat_o;
   logic        rsp_err_o;
   logic        rsp_tmo_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;
   logic        wbm_err_i;

   modport master (
      input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
             wbm_dat_i, wbm_ack_i, wbm_err_i,
      output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_tmo_o,
             wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
   );

   modport slave (
      output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
             wbm_dat_i, wbm_ack_i, wbm_err_i,
      input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_tmo_o,
             wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
   );
endinterface

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone classic single-transfer initiator; one command in flight, one response
// (ack, err or timeout) per bus cycle.
module wb_cmd_master #(
   parameter int TIMEOUT = 256
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   wb_cmd_master_if.master bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  r_state;
   logic        r_we;
   logic [31:0] r_adr;
   logic [31:0] r_dat;
   logic [3:0]  r_sel;
   logic [15:0] r_cnt;
   logic [31:0] r_rsp_dat;
   logic        r_err;
   logic        r_tmo;
   logic        w_cyc;
   logic        w_accept;
   logic        w_last;

   assign w_cyc    = r_state == S_BUS;
   assign w_accept = bus.cmd_valid_i & bus.cmd_ready_o;
   assign w_last   = r_cnt == 16'(TIMEOUT - 1);

   assign bus.cmd_ready_o = (r_state == S_IDLE) & ~wb_rst_i;
   assign bus.rsp_valid_o = r_state == S_RESP;
   assign bus.rsp_dat_o   = r_rsp_dat;
   assign bus.rsp_err_o   = r_err;
   assign bus.rsp_tmo_o   = r_tmo;
   // Command fields are only presented on the bus while the cycle is open.
   assign bus.wbm_cyc_o   = w_cyc;
   assign bus.wbm_stb_o   = w_cyc;
   assign bus.wbm_we_o    = w_cyc & r_we;
   assign bus.wbm_sel_o   = w_cyc ? r_sel : 4'd0;
   assign bus.wbm_adr_o   = w_cyc ? r_adr : 32'd0;
   assign bus.wbm_dat_o   = w_cyc ? r_dat : 32'd0;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state   <= S_IDLE;
         r_we      <= 1'b0;
         r_adr     <= 32'd0;
         r_dat     <= 32'd0;
         r_sel     <= 4'd0;
         r_cnt     <= 16'd0;
         r_rsp_dat <= 32'd0;
         r_err     <= 1'b0;
         r_tmo     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_state <= S_BUS;
               r_we    <= bus.cmd_we_i;
               r_adr   <= bus.cmd_adr_i;
               r_dat   <= bus.cmd_dat_i;
               r_sel   <= bus.cmd_sel_i;
               r_cnt   <= 16'd0;
            end
            // err beats ack, and any termination beats the timeout terminal count.
            S_BUS: if (bus.wbm_err_i) begin
               r_state   <= S_RESP;
               r_err     <= 1'b1;
               r_rsp_dat <= 32'd0;
            end else if (bus.wbm_ack_i) begin
               r_state   <= S_RESP;
               r_rsp_dat <= r_we ? 32'd0 : bus.wbm_dat_i;
            end else if (w_last) begin
               r_state   <= S_RESP;
               r_tmo     <= 1'b1;
               r_rsp_dat <= 32'd0;
            end else begin
               r_cnt <= r_cnt + 16'd1;
            end
            S_RESP: if (bus.rsp_ready_i) begin
               r_state   <= S_IDLE;
               r_rsp_dat <= 32'd0;
               r_err     <= 1'b0;
               r_tmo     <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed vector table plus hand-written backpressure and reset sequences.
module tb_wb_cmd_master;
   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          wt;
      int          term;
      logic [31:0] rdata;
      int          exp_stb;
      logic [31:0] exp_dat;
      logic        exp_err;
      logic        exp_tmo;
   } vec_t;

   localparam int T_ACK = 0, T_ERR = 1, T_BOTH = 2, T_NONE = 3;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;
   vec_t vecs[8];

   wb_cmd_master_if bus();

   wb_cmd_master #(.TIMEOUT(8)) dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_txn(input vec_t v);
      int k;
      bit bad;
      @(negedge clk);
      chk("cmd_ready_idle", bus.cmd_ready_o, 1);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_we_i    = v.we;
      bus.cmd_adr_i   = v.adr;
      bus.cmd_dat_i   = v.dat;
      bus.cmd_sel_i   = v.sel;
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      bus.cmd_adr_i   = 32'hFFFF_FFFF;
      bus.cmd_dat_i   = 32'hFFFF_FFFF;
      k   = 0;
      bad = 0;
      while (bus.wbm_stb_o === 1'b1 && k < 20) begin
         k++;
         if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_we_o !== v.we || bus.wbm_adr_o !== v.adr ||
             bus.wbm_dat_o !== v.dat || bus.wbm_sel_o !== v.sel || bus.cmd_ready_o !== 1'b0 ||
             bus.rsp_valid_o !== 1'b0)
            bad = 1;
         bus.wbm_ack_i = (k == v.wt + 1) && (v.term == T_ACK || v.term == T_BOTH);
         bus.wbm_err_i = (k == v.wt + 1) && (v.term == T_ERR || v.term == T_BOTH);
         bus.wbm_dat_i = (k == v.wt + 1) ? v.rdata : 32'hBAD0_0000 + 32'(k);
         @(negedge clk);
      end
      bus.wbm_ack_i = 1'b0;
      bus.wbm_err_i = 1'b0;
      chk("stb_cycles", k, v.exp_stb);
      chk("bus_fields", {31'd0, bad}, 0);
      chk("idle_ctl", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}, 0);
      chk("idle_adr", bus.wbm_adr_o, 0);
      chk("idle_dat", bus.wbm_dat_o, 0);
      chk("rsp_valid", bus.rsp_valid_o, 1);
      chk("rsp_dat", bus.rsp_dat_o, v.exp_dat);
      chk("rsp_err", bus.rsp_err_o, v.exp_err);
      chk("rsp_tmo", bus.rsp_tmo_o, v.exp_tmo);
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      chk("rsp_done", bus.rsp_valid_o, 0);
      chk("flags_clear", {bus.rsp_err_o, bus.rsp_tmo_o}, 0);
      chk("cmd_ready_after", bus.cmd_ready_o, 1);
   endtask

   initial begin
      bit bad;
      vecs[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, T_ACK,  32'h7777_7777, 1, 32'h0,          1'b0, 1'b0};
      vecs[1] = '{1'b0, 32'h3000_0010, 32'h0,         4'h3, 3, T_ACK,  32'h1234_5678, 4, 32'h1234_5678, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 32'h3000_0014, 32'h0,         4'hF, 1, T_ERR,  32'hAAAA_5555, 2, 32'h0,          1'b1, 1'b0};
      vecs[3] = '{1'b0, 32'h3000_0018, 32'h0,         4'h1, 0, T_BOTH, 32'h1111_1111, 1, 32'h0,          1'b1, 1'b0};
      vecs[4] = '{1'b0, 32'h3000_001C, 32'h0,         4'hC, 0, T_NONE, 32'h2222_2222, 8, 32'h0,          1'b0, 1'b1};
      vecs[5] = '{1'b0, 32'h3000_0020, 32'h0,         4'hF, 7, T_ACK,  32'hCAFE_F00D, 8, 32'hCAFE_F00D, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 32'h3000_0024, 32'h5555_AAAA, 4'h6, 2, T_ERR,  32'h3333_3333, 3, 32'h0,          1'b1, 1'b0};
      vecs[7] = '{1'b1, 32'h3000_0028, 32'h0102_0304, 4'h8, 7, T_BOTH, 32'h4444_4444, 8, 32'h0,          1'b1, 1'b0};
      n_chk  = 0;
      n_fail = 0;
      rst             = 1'b1;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_we_i    = 1'b0;
      bus.cmd_adr_i   = 32'd0;
      bus.cmd_dat_i   = 32'd0;
      bus.cmd_sel_i   = 4'd0;
      bus.rsp_ready_i = 1'b0;
      bus.wbm_dat_i   = 32'd0;
      bus.wbm_ack_i   = 1'b0;
      bus.wbm_err_i   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", bus.cmd_ready_o, 0);
      chk("rst_ctl", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.rsp_valid_o,
                      bus.rsp_err_o, bus.rsp_tmo_o}, 0);
      chk("rst_adr", bus.wbm_adr_o, 0);
      chk("rst_wdat", bus.wbm_dat_o, 0);
      chk("rst_rdat", bus.rsp_dat_o, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_cmd_ready", bus.cmd_ready_o, 1);

      for (int i = 0; i < 8; i++) run_txn(vecs[i]);

      // Backpressure: response held 5 cycles while a second command waits and stray ack/err toggle.
      @(negedge clk);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_we_i    = 1'b0;
      bus.cmd_adr_i   = 32'h3000_0030;
      bus.cmd_dat_i   = 32'd0;
      bus.cmd_sel_i   = 4'hF;
      @(negedge clk);
      chk("bp_stb", bus.wbm_stb_o, 1);
      bus.cmd_valid_i = 1'b0;
      bus.wbm_ack_i   = 1'b1;
      bus.wbm_dat_i   = 32'h5A5A_5A5A;
      @(negedge clk);
      chk("bp_rsp_valid", bus.rsp_valid_o, 1);
      chk("bp_rsp_dat", bus.rsp_dat_o, 32'h5A5A_5A5A);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_we_i    = 1'b1;
      bus.cmd_adr_i   = 32'h3000_0020;
      bus.cmd_dat_i   = 32'h0BAD_F00D;
      bus.cmd_sel_i   = 4'h5;
      bus.wbm_err_i   = 1'b1;
      bus.wbm_dat_i   = 32'hFFFF_FFFF;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.rsp_valid_o !== 1'b1 || bus.rsp_dat_o !== 32'h5A5A_5A5A || bus.rsp_err_o !== 1'b0 ||
             bus.rsp_tmo_o !== 1'b0 || bus.cmd_ready_o !== 1'b0 || bus.wbm_cyc_o !== 1'b0)
            bad = 1;
      end
      chk("bp_stable", {31'd0, bad}, 0);
      bus.wbm_ack_i   = 1'b0;
      bus.wbm_err_i   = 1'b0;
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      chk("bp_hs_ready", bus.cmd_ready_o, 1);
      chk("bp_hs_nocyc", {bus.wbm_cyc_o, bus.rsp_valid_o}, 0);
      @(negedge clk);
      chk("bp_next_cyc", bus.wbm_cyc_o, 1);
      chk("bp_next_adr", bus.wbm_adr_o, 32'h3000_0020);
      chk("bp_next_dat", bus.wbm_dat_o, 32'h0BAD_F00D);
      bus.cmd_valid_i = 1'b0;
      bus.wbm_ack_i   = 1'b1;
      @(negedge clk);
      bus.wbm_ack_i = 1'b0;
      chk("bp_wr_valid", bus.rsp_valid_o, 1);
      chk("bp_wr_dat", bus.rsp_dat_o, 0);
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;

      // Reset on the 3rd strobe cycle aborts the transfer silently.
      bus.cmd_valid_i = 1'b1;
      bus.cmd_we_i    = 1'b0;
      bus.cmd_adr_i   = 32'h3000_0040;
      bus.cmd_sel_i   = 4'hF;
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("mr_stb3", bus.wbm_stb_o, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mr_cyc", {bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
      chk("mr_rsp", bus.rsp_valid_o, 0);
      chk("mr_ready", bus.cmd_ready_o, 0);
      rst = 1'b0;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.rsp_valid_o !== 1'b0 || bus.wbm_cyc_o !== 1'b0) bad = 1;
      end
      chk("mr_quiet", {31'd0, bad}, 0);
      run_txn(vecs[1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
